// File: rtl/rram_mvm_accum_pkg.sv
// rtl/rram_mvm_accum_pkg.sv - shared types, dimensions and bus helpers for the MVM readout accumulator
package rram_pkg;

   localparam int NUM_ADCS   = 32;
   localparam int ADC_W      = 4;
   localparam int NUM_SEL    = 16;
   localparam int SEL_W      = 4;
   localparam int ACC_W      = 16;
   localparam int SETTLE_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_WAIT_PLANE,
      ST_DRAIN
   } state_e;

   function automatic logic [ADC_W-1:0] adc_sample(input logic [NUM_ADCS*ADC_W-1:0] bus,
                                                    input int unsigned idx);
      return bus[idx*ADC_W +: ADC_W];
   endfunction

endpackage

// File: rtl/rram_mvm_accum_if.sv
// rtl/rram_mvm_accum_if.sv - control, ADC and result-stream signals of the MVM readout accumulator
interface rram_mvm_accum_if;
   import rram_pkg::*;

   logic                      START;
   logic [3:0]                NUM_PLANES;
   logic                      BUSY;
   logic                      PLANE_DONE;
   logic                      NEXT_PLANE;
   logic [SEL_W-1:0]          ADCSEL;
   logic                      ADC_VALID;
   logic                      ADC_READY;
   logic [NUM_ADCS*ADC_W-1:0] ADCOUT;
   logic                      RES_VALID;
   logic                      RES_READY;
   logic [NUM_ADCS*ACC_W-1:0] RES_DATA;
   logic [SEL_W-1:0]          RES_SEL;
   logic                      RES_LAST;

   modport master (
      output START, NUM_PLANES, NEXT_PLANE, ADC_VALID, ADCOUT, RES_READY,
      input  BUSY, PLANE_DONE, ADCSEL, ADC_READY, RES_VALID, RES_DATA, RES_SEL, RES_LAST
   );

   modport slave (
      input  START, NUM_PLANES, NEXT_PLANE, ADC_VALID, ADCOUT, RES_READY,
      output BUSY, PLANE_DONE, ADCSEL, ADC_READY, RES_VALID, RES_DATA, RES_SEL, RES_LAST
   );

endinterface

// File: rtl/rram_mvm_accum_acc_bank.sv
// rtl/rram_mvm_accum_acc_bank.sv - NUM_SEL x NUM_ADCS shift-accumulate register array
module rram_acc_bank
   import rram_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic                      wr_en_i,
   input  logic [SEL_W-1:0]          wr_sel_i,
   input  logic                      wr_clear_i,
   input  logic [NUM_ADCS*ADC_W-1:0] wr_sample_i,
   input  logic [SEL_W-1:0]          rd_sel_i,
   output logic [NUM_ADCS*ACC_W-1:0] rd_data_o
);

   logic [NUM_ADCS-1:0][ACC_W-1:0] acc_q [NUM_SEL];
   logic [NUM_ADCS-1:0][ACC_W-1:0] row_d;

   // First plane overwrites, so no explicit clear is needed between MVMs.
   always_comb begin
      row_d = acc_q[wr_sel_i];
      for (int i = 0; i < NUM_ADCS; i++) begin
         if (wr_clear_i)
            row_d[i] = ACC_W'(adc_sample(wr_sample_i, i));
         else
            row_d[i] = (acc_q[wr_sel_i][i] << 1) + ACC_W'(adc_sample(wr_sample_i, i));
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int s = 0; s < NUM_SEL; s++)
            acc_q[s] <= '0;
      end else if (wr_en_i) begin
         acc_q[wr_sel_i] <= row_d;
      end
   end

   assign rd_data_o = acc_q[rd_sel_i];

endmodule

// File: rtl/rram_mvm_accum.sv
// rtl/rram_mvm_accum.sv - bit-serial MVM readout: ADC select sweep, shift-accumulate, result drain
module rram_mvm_accum
   import rram_pkg::*;
#(
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic             CLK,
   input  logic             RESET_N,
   rram_mvm_accum_if.slave  bus
);

   generate
      if (ACC_W < ADC_W + 8) begin : g_bad_acc_w
         $error("ACC_W must be at least ADC_W+8");
      end
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("SETTLE must be in 1..15");
      end
   endgenerate

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_SEL - 1);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] adcsel_q, adcsel_d;
   logic [3:0]       plane_q, plane_d;
   logic [3:0]       last_plane_q, last_plane_d;
   logic [3:0]       settle_cnt_q, settle_cnt_d;
   logic             plane_done_q, plane_done_d;
   logic             acc_wr;
   logic [NUM_ADCS*ACC_W-1:0] rd_data;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         adcsel_q     <= '0;
         plane_q      <= '0;
         last_plane_q <= '0;
         settle_cnt_q <= '0;
         plane_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         adcsel_q     <= adcsel_d;
         plane_q      <= plane_d;
         last_plane_q <= last_plane_d;
         settle_cnt_q <= settle_cnt_d;
         plane_done_q <= plane_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      plane_d      = plane_q;
      last_plane_d = last_plane_q;
      settle_cnt_d = settle_cnt_q;
      plane_done_d = 1'b0;
      acc_wr       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.START) begin
               last_plane_d = (bus.NUM_PLANES == 4'd0) ? 4'd0 : bus.NUM_PLANES - 4'd1;
               sel_d        = '0;
               plane_d      = '0;
               settle_cnt_d = '0;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_cnt_d = '0;
               state_d      = ST_SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            if (bus.ADC_VALID) begin
               acc_wr = 1'b1;
               if (sel_q != SEL_LAST) begin
                  sel_d   = sel_q + 1'b1;
                  state_d = ST_SETTLE;
               end else begin
                  plane_done_d = 1'b1;
                  sel_d        = '0;
                  if (plane_q == last_plane_q) begin
                     state_d = ST_DRAIN;
                  end else begin
                     plane_d = plane_q + 4'd1;
                     state_d = ST_WAIT_PLANE;
                  end
               end
            end
         end
         ST_WAIT_PLANE: begin
            // A NEXT_PLANE coincident with PLANE_DONE predates the done pulse and is dropped.
            if (bus.NEXT_PLANE && !plane_done_q)
               state_d = ST_SETTLE;
         end
         ST_DRAIN: begin
            if (bus.RES_READY) begin
               if (sel_q == SEL_LAST) begin
                  sel_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  sel_d = sel_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // ADCSEL moves only when a new settle window opens, otherwise it holds.
      adcsel_d = (state_d == ST_SETTLE) ? sel_d : adcsel_q;
   end

   rram_acc_bank u_acc_bank (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .wr_en_i     (acc_wr),
      .wr_sel_i    (sel_q),
      .wr_clear_i  (plane_q == 4'd0),
      .wr_sample_i (bus.ADCOUT),
      .rd_sel_i    (sel_q),
      .rd_data_o   (rd_data)
   );

   assign bus.BUSY       = (state_q != ST_IDLE);
   assign bus.PLANE_DONE = plane_done_q;
   assign bus.ADCSEL     = adcsel_q;
   assign bus.ADC_READY  = (state_q == ST_SAMPLE);
   assign bus.RES_VALID  = (state_q == ST_DRAIN);
   assign bus.RES_DATA   = bus.RES_VALID ? rd_data : '0;
   assign bus.RES_SEL    = bus.RES_VALID ? sel_q : '0;
   assign bus.RES_LAST   = bus.RES_VALID && (sel_q == SEL_LAST);

endmodule

// File: tb/tb_rram_mvm_accum.sv
// tb/tb_rram_mvm_accum.sv - directed table-driven bench for rram_mvm_accum
module tb_rram_mvm_accum;
   import rram_pkg::*;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;

   rram_mvm_accum_if bus_if ();

   rram_mvm_accum #(.SETTLE(2)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus_if.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int              np;
      logic [31:0]     samp;      // nibble p = sample value of plane p
      bit              vary;      // xor in column/select low bits
      bit              bp;        // RES_READY pattern 1-0-0-1
      bit              mid_start;
      logic [15:0]     exp_col0;
      int              chk_sel;
   } vec_t;

   vec_t        vecs [6];
   int          n_pass = 0;
   int          n_total = 0;
   int          tb_plane = 0;
   logic [31:0] cur_samp = '0;
   bit          cur_vary = 1'b0;

   function automatic logic [3:0] sval(input logic [31:0] samp, input bit vary,
                                       input int p, input int i, input int s);
      logic [3:0] b;
      if (p > 7) return 4'h0;
      b = samp[p*4 +: 4];
      if (vary) b = b ^ 4'((i % 4) ^ (s % 4));
      return b;
   endfunction

   always_comb begin
      bus_if.ADCOUT = '0;
      for (int i = 0; i < NUM_ADCS; i++)
         bus_if.ADCOUT[i*ADC_W +: ADC_W] = sval(cur_samp, cur_vary, tb_plane, i, int'(bus_if.ADCSEL));
   end

   // Weighted sum of bit-plane samples, MSB plane first, modulo 2^16.
   function automatic logic [511:0] exp_beat(input int npe, input int s,
                                             input logic [31:0] samp, input bit vary);
      logic [511:0] r;
      logic [15:0]  acc;
      r = '0;
      for (int i = 0; i < NUM_ADCS; i++) begin
         acc = 16'h0;
         for (int p = 0; p < npe; p++)
            acc = acc + (16'(sval(samp, vary, p, i, s)) << (npe - 1 - p));
         r[i*16 +: 16] = acc;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int npe, cyc, pd_cnt, smp_cnt, beats, low_run, settle_viol, stable_viol, dcyc;
      bit done, nxt_arm, prev_stall;
      logic [511:0] stall_data;
      logic [3:0]   stall_sel;
      npe = (v.np == 0) ? 1 : v.np;
      cur_samp = v.samp; cur_vary = v.vary; tb_plane = 0;
      cyc = 0; pd_cnt = 0; smp_cnt = 0; beats = 0; low_run = 0;
      settle_viol = 0; stable_viol = 0; dcyc = 0;
      done = 0; nxt_arm = 0; prev_stall = 0; stall_data = '0; stall_sel = '0;
      bus_if.START = 1'b1;
      bus_if.NUM_PLANES = 4'(v.np);
      bus_if.ADC_VALID = 1'b1;
      bus_if.RES_READY = 1'b1;
      while (!done && cyc < 3000) begin
         @(negedge CLK);
         cyc++;
         bus_if.START = 1'b0;
         bus_if.NEXT_PLANE = 1'b0;
         if (v.mid_start && cyc == 40) begin
            bus_if.START = 1'b1;
            bus_if.NUM_PLANES = 4'd1;
         end
         if (bus_if.ADC_READY) begin
            if (low_run < 2) settle_viol++;
            low_run = 0;
            smp_cnt++;
         end else begin
            low_run++;
         end
         if (nxt_arm) begin
            bus_if.NEXT_PLANE = 1'b1;
            nxt_arm = 0;
         end
         if (bus_if.PLANE_DONE) begin
            pd_cnt++;
            tb_plane++;
            if (pd_cnt < npe) nxt_arm = 1;
         end
         if (prev_stall && (bus_if.RES_DATA !== stall_data || bus_if.RES_SEL !== stall_sel))
            stable_viol++;
         if (bus_if.RES_VALID) begin
            bus_if.RES_READY = v.bp ? ((dcyc % 4 == 0) || (dcyc % 4 == 3)) : 1'b1;
            dcyc++;
         end else begin
            bus_if.RES_READY = 1'b1;
         end
         prev_stall = bus_if.RES_VALID && !bus_if.RES_READY;
         stall_data = bus_if.RES_DATA;
         stall_sel  = bus_if.RES_SEL;
         if (bus_if.RES_VALID && bus_if.RES_READY) begin
            check($sformatf("v%0d beat%0d data", idx, beats), bus_if.RES_DATA,
                  exp_beat(npe, beats, v.samp, v.vary));
            check($sformatf("v%0d beat%0d sel", idx, beats), 512'(bus_if.RES_SEL), 512'(beats));
            check($sformatf("v%0d beat%0d last", idx, beats), 512'(bus_if.RES_LAST),
                  512'(beats == NUM_SEL - 1));
            if (int'(bus_if.RES_SEL) == v.chk_sel)
               check($sformatf("v%0d col0 hand", idx), 512'(bus_if.RES_DATA[15:0]), 512'(v.exp_col0));
            beats++;
            if (bus_if.RES_LAST || beats >= 40) done = 1;
         end
      end
      if (!done) check($sformatf("v%0d timeout", idx), 512'(0), 512'(1));
      @(negedge CLK);
      check($sformatf("v%0d busy after last", idx), 512'(bus_if.BUSY), 512'(0));
      check($sformatf("v%0d valid after last", idx), 512'(bus_if.RES_VALID), 512'(0));
      check($sformatf("v%0d plane_done pulses", idx), 512'(pd_cnt), 512'(npe));
      check($sformatf("v%0d samples", idx), 512'(smp_cnt), 512'(16 * npe));
      check($sformatf("v%0d beats", idx), 512'(beats), 512'(16));
      check($sformatf("v%0d settle violations", idx), 512'(settle_viol), 512'(0));
      if (v.bp) check($sformatf("v%0d stall stability", idx), 512'(stable_viol), 512'(0));
      bus_if.ADC_VALID = 1'b0;
   endtask

   initial begin
      vec_t vr;
      int   cyc;
      bus_if.START = 1'b0;
      bus_if.NUM_PLANES = 4'd0;
      bus_if.NEXT_PLANE = 1'b0;
      bus_if.ADC_VALID = 1'b0;
      bus_if.RES_READY = 1'b1;

      vecs[0] = '{np:1, samp:32'hAAAAAAAA, vary:0, bp:0, mid_start:0, exp_col0:16'h000A, chk_sel:15};
      vecs[1] = '{np:2, samp:32'h00000053, vary:0, bp:0, mid_start:0, exp_col0:16'h000B, chk_sel:2};
      vecs[2] = '{np:8, samp:32'hFFFFFFFF, vary:0, bp:0, mid_start:1, exp_col0:16'h0EF1, chk_sel:7};
      vecs[3] = '{np:1, samp:32'h0000000A, vary:1, bp:1, mid_start:0, exp_col0:16'h000A, chk_sel:4};
      vecs[4] = '{np:0, samp:32'h00000007, vary:1, bp:0, mid_start:0, exp_col0:16'h0007, chk_sel:0};
      vecs[5] = '{np:3, samp:32'h00000101, vary:1, bp:1, mid_start:0, exp_col0:16'h0005, chk_sel:8};

      repeat (2) @(negedge CLK);
      check("reset busy", 512'(bus_if.BUSY), 512'(0));
      check("reset adc_ready", 512'(bus_if.ADC_READY), 512'(0));
      check("reset adcsel", 512'(bus_if.ADCSEL), 512'(0));
      check("reset res_valid", 512'(bus_if.RES_VALID), 512'(0));
      check("reset res_data", bus_if.RES_DATA, 512'(0));
      RESET_N = 1'b1;
      @(negedge CLK);

      for (int k = 0; k < 6; k++) begin
         run_vec(vecs[k], k);
         repeat (2) @(negedge CLK);
      end

      // Reset in the middle of plane 1 sampling, then a clean single-plane run.
      cur_samp = 32'h00000053; cur_vary = 0; tb_plane = 0;
      bus_if.START = 1'b1; bus_if.NUM_PLANES = 4'd2; bus_if.ADC_VALID = 1'b1;
      cyc = 0;
      while (cyc < 2000 && !(tb_plane == 1 && bus_if.ADC_READY && bus_if.ADCSEL >= 4'd3)) begin
         @(negedge CLK);
         cyc++;
         bus_if.START = 1'b0;
         bus_if.NEXT_PLANE = 1'b0;
         if (bus_if.PLANE_DONE) tb_plane = 1;
         else if (tb_plane == 1 && cyc % 8 == 0 && !bus_if.ADC_READY && bus_if.BUSY)
            bus_if.NEXT_PLANE = 1'b1;
      end
      check("reset test reached plane1", 512'(tb_plane == 1 && bus_if.ADC_READY), 512'(1));
      #2 RESET_N = 1'b0;
      #1;
      check("async reset busy", 512'(bus_if.BUSY), 512'(0));
      check("async reset adc_ready", 512'(bus_if.ADC_READY), 512'(0));
      check("async reset adcsel", 512'(bus_if.ADCSEL), 512'(0));
      check("async reset outputs", 512'({bus_if.RES_VALID, bus_if.RES_LAST, bus_if.PLANE_DONE, bus_if.RES_SEL}), 512'(0));
      @(negedge CLK);
      RESET_N = 1'b1;
      bus_if.ADC_VALID = 1'b0;
      @(negedge CLK);
      vr = '{np:1, samp:32'h00000001, vary:0, bp:0, mid_start:0, exp_col0:16'h0001, chk_sel:0};
      run_vec(vr, 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rram_mvm_accum.md
Name: rram_mvm_accum

Overview:
- Downstream consumer of the RRAM core's ADC outputs; runs the readout half of a bit-serial MVM.
- Per input bit-plane, sweeps the ADC mux select across all column groups and samples the ADC bank.
- Shift-accumulates samples into per-column partial sums, MSB-first.
- After the last plane, drains one result beat per column group over a valid/ready interface to the host/writeback stage.

Parameters:
- NUM_ADCS, 32, ADCs sampled in parallel per select
- ADC_W, 4, bits per ADC sample
- NUM_SEL, 16, column groups (ADC mux select values)
- SEL_W, 4, width of the ADC select
- ACC_W, 16, accumulator width per column; must be >= ADC_W+8 (elaboration assertion)
- SETTLE, 2, CLK cycles to wait after a select change before sampling (1..15)

Ports:
- CLK  in  1  single clock
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse: begin an MVM; ignored while BUSY
- NUM_PLANES  in  4  input bit-planes for this MVM (1..8; 0 treated as 1); captured on START
- BUSY  out  1  high from accepted START until the last result handshake
- PLANE_DONE  out  1  one-cycle pulse when all selects of a plane are sampled; upstream then loads the next WL plane
- NEXT_PLANE  in  1  upstream pulse: next plane is loaded on WL
- ADCSEL  out  SEL_W  drives the core's ADC select
- ADC_VALID  in  1  ADC bank sample valid (already in CLK domain)
- ADC_READY  out  1  block accepts a sample
- ADCOUT  in  NUM_ADCS*ADC_W  flattened ADC outputs; ADC i occupies bits [i*ADC_W +: ADC_W]
- RES_VALID  out  1  result beat valid
- RES_READY  in  1  downstream accepts a beat
- RES_DATA  out  NUM_ADCS*ACC_W  accumulators of one select group; column i occupies bits [i*ACC_W +: ACC_W]
- RES_SEL  out  SEL_W  select group of the current beat
- RES_LAST  out  1  high on the beat with RES_SEL = NUM_SEL-1

Behaviour:
- Reset (async assert, sync deassert use):
  - state IDLE
  - all outputs 0
  - plane/select counters 0
  - accumulators 0
- States and transitions:
  - IDLE: on START, capture NUM_PLANES, set BUSY, sel=0, plane=0, go to SETTLE.
  - SETTLE: count SETTLE cycles with ADCSEL=sel and ADC_READY=0, then go to SAMPLE.
  - SAMPLE: ADC_READY=1. On a handshake (ADC_VALID & ADC_READY), for each column i: acc[sel][i] <= (plane==0) ? sample : (acc[sel][i]<<1) + sample. Arithmetic is unsigned, zero-extended, truncated to ACC_W.
    - If sel < NUM_SEL-1: increment sel and go to SETTLE.
    - Otherwise: pulse PLANE_DONE in the next cycle.
      - If plane == NUM_PLANES-1: go to DRAIN with sel=0.
      - Else: increment plane, set sel=0, go to WAIT_PLANE.
  - WAIT_PLANE: ADC_READY=0. On NEXT_PLANE go to SETTLE.
  - DRAIN: RES_VALID=1 with RES_DATA=acc[sel], RES_SEL=sel, RES_LAST=(sel==NUM_SEL-1). Data is stable while RES_VALID & !RES_READY.
    - On handshake, increment sel.
    - After the LAST handshake, go to IDLE next cycle; BUSY and RES_VALID drop that same cycle.
- Latency: one sample per (SETTLE+1) cycles minimum. First sample accepted no earlier than SETTLE+1 cycles after START.
- ADC_VALID outside SAMPLE is ignored; no sample is consumed.
- NEXT_PLANE outside WAIT_PLANE is ignored. NEXT_PLANE arriving in the same cycle as PLANE_DONE is lost; upstream must wait for PLANE_DONE.
- START while BUSY is ignored; captured parameters stay unchanged.
- ADCSEL holds its last value in WAIT_PLANE, DRAIN and IDLE.
- RES_READY held high gives one beat per cycle: NUM_SEL cycles of drain.
- Reset mid-operation: immediate return to IDLE. Partial sums are discarded; no result beats are emitted.

Decomposition:
- Package rram_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, WAIT_PLANE, DRAIN)
  - NUM_ADCS/ADC_W/NUM_SEL/SEL_W/ACC_W defaults
  - helper function extracting ADC i from the flattened bus
- Sub-module rram_acc_bank: NUM_SEL x NUM_ADCS accumulator register array.
  - Write port: sel, clear_shift flag, sample vector.
  - Read port: sel, returns the packed ACC_W vector.
- The FSM, counters and handshakes stay in the top module.

Test Plan:
- Single plane, NUM_PLANES=1, every ADC = 4'hA for all 16 selects, RES_READY=1 → 16 beats, each column = 16'h000A, RES_LAST on RES_SEL=15, BUSY falls after beat 15.
- Two planes: plane0 samples 3, plane1 samples 5 on column 0 of sel 2; NEXT_PLANE after PLANE_DONE → acc = 3*2+5 = 11 in column 0 of beat RES_SEL=2; exactly two PLANE_DONE pulses.
- Eight planes, all samples 4'hF → every column = 15*255 = 16'h0EF1, with no truncation.
- Backpressure: RES_READY toggles 1-0-0-1 during DRAIN → RES_DATA/RES_SEL are stable while stalled, and no beat is dropped or duplicated (16 beats total).
- SETTLE=2, ADC_VALID held high from START → ADC_READY low for 2 cycles after every ADCSEL change; exactly 16 samples accepted per plane; START pulsed mid-run is ignored.
- RESET_N asserted during plane 1 SAMPLE → all outputs 0 asynchronously. A following START with NUM_PLANES=1 and samples 1 yields columns = 1, with no stale accumulation.
